// File: rtl/mips_mem_pkg.sv
// Shared encodings for the unified-memory port arbiter: access modes, arbiter
// FSM states and requester IDs.
package mips_mem_pkg;

    typedef logic [1:0] arb_state_t;

    localparam logic [1:0] MODE_WORD  = 2'b00;
    localparam logic [1:0] MODE_SBYTE = 2'b01;
    localparam logic [1:0] MODE_UBYTE = 2'b10;

    localparam arb_state_t ARB_IDLE   = 2'd0;
    localparam arb_state_t ARB_ACCESS = 2'd1;
    localparam arb_state_t ARB_RESP   = 2'd2;

    localparam logic SRC_CPU = 1'b0;
    localparam logic SRC_DBG = 1'b1;

    localparam int WAIT_W = 8;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker. Holds the last-granted source so that a tie
// goes to whoever did not win last time.
module rr_arb2
    import mips_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_valid,
    output logic       gnt_src
);

    logic last_grant;

    // req[0] is the CPU, req[1] is the debug port
    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11)
            gnt_src = ~last_grant;
        else
            gnt_src = req[1] ? SRC_DBG : SRC_CPU;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_grant <= SRC_DBG;
        else if (advance && gnt_valid)
            last_grant <= gnt_src;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and debug-port transactions onto the single unified memory,
// with a bounded wait for mem_ready and a sticky timeout flag.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_mode,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_done,
    output logic          cpu_stall,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [1:0]    dbg_mode,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_done,

    output logic          mem_req,
    output logic          mem_we,
    output logic [1:0]    mem_mode,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,

    output logic          err_timeout,
    output logic          err_src,
    input  logic          err_clr
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    arb_state_t        state;
    logic              owner;
    logic [WAIT_W-1:0] wait_cnt;
    logic              gnt_valid;
    logic              gnt_src;
    logic              timed_out;
    logic              access_end;
    logic [DW-1:0]     rd_value;

    rr_arb2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       ({dbg_req, cpu_req}),
        .advance   (state == ARB_IDLE),
        .gnt_valid (gnt_valid),
        .gnt_src   (gnt_src)
    );

    // A ready on the last allowed cycle still counts as a normal completion
    assign timed_out  = (state == ARB_ACCESS) && !mem_ready && (wait_cnt == WAIT_LAST);
    assign access_end = (state == ARB_ACCESS) && (mem_ready || timed_out);
    assign rd_value   = mem_ready ? mem_rdata : '0;

    assign cpu_stall  = cpu_req & ~cpu_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            owner     <= SRC_CPU;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_mode  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            cpu_done  <= 1'b0;
            dbg_done  <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            dbg_done <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (gnt_valid) begin
                        owner    <= gnt_src;
                        mem_req  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= ARB_ACCESS;
                        if (gnt_src == SRC_DBG) begin
                            mem_we    <= dbg_we;
                            mem_mode  <= dbg_mode;
                            mem_addr  <= dbg_addr;
                            mem_wdata <= dbg_wdata;
                        end else begin
                            mem_we    <= cpu_we;
                            mem_mode  <= cpu_mode;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end
                    end
                end
                ARB_ACCESS: begin
                    if (access_end) begin
                        mem_req <= 1'b0;
                        state   <= ARB_RESP;
                        if (owner == SRC_DBG) begin
                            dbg_done <= 1'b1;
                            if (!mem_we)
                                dbg_rdata <= rd_value;
                        end else begin
                            cpu_done <= 1'b1;
                            if (!mem_we)
                                cpu_rdata <= rd_value;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ARB_RESP: begin
                    wait_cnt <= '0;
                    state    <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // A timeout in the same cycle as err_clr re-arms the flag with the new source
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_timeout <= 1'b0;
            err_src     <= 1'b0;
        end else if (timed_out) begin
            err_timeout <= 1'b1;
            if (!err_timeout || err_clr)
                err_src <= owner;
        end else if (err_clr) begin
            err_timeout <= 1'b0;
            err_src     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run scored against
// a transaction-level model of the arbitration and memory behaviour.
module tb_mem_port_arbiter;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [1:0]  cpu_mode;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_done, cpu_stall;
    logic        dbg_req, dbg_we;
    logic [1:0]  dbg_mode;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_done;
    logic        mem_req, mem_we;
    logic [1:0]  mem_mode;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        err_timeout, err_src, err_clr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_mode(cpu_mode), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_mode(dbg_mode), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err_timeout(err_timeout), .err_src(err_src), .err_clr(err_clr)
    );

    // Behavioural memory: answers lat cycles after mem_req rises
    int          lat = 1;
    bit          no_ready = 1'b0;
    bit          stray_ready = 1'b0;
    int          acc_cnt = 0;
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] exp_cpu_rd = 32'h0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : (a ^ 32'hA5A5_0000);
    endfunction

    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_req && !no_ready) begin
                if (acc_cnt >= lat) begin
                    mem_ready = 1'b1;
                    if (mem_we) begin
                        mem_rdata = $urandom;
                        mem_model[mem_addr] = mem_wdata;
                    end else begin
                        mem_rdata = mem_rd(mem_addr);
                    end
                    acc_cnt = 0;
                end else begin
                    acc_cnt++;
                end
            end else begin
                acc_cnt = 0;
                if (!mem_req && stray_ready) begin
                    mem_ready = 1'b1;
                    mem_rdata = 32'hBAD0_BAD0;
                end
            end
        end
    end

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_mode = MODE_WORD; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_mode = MODE_WORD; dbg_addr = 0; dbg_wdata = 0;
        err_clr = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_cpu_rd = 32'h0;
    endtask

    // Returns at the negedge where the selected done is seen
    task automatic wait_done(input bit src, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = (src == SRC_DBG) ? dbg_done : cpu_done;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        tests++;
        if ({cpu_rdata, cpu_done, cpu_stall, dbg_rdata, dbg_done, mem_req, mem_we, mem_mode,
             mem_addr, mem_wdata, err_timeout, err_src} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got cpu_done=%b mem_req=%b mem_addr=%h err=%b want all zero",
                     cpu_done, mem_req, mem_addr, err_timeout);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cpu_read();
        lat = 2;
        mem_model[32'h10] = 32'hDEADBEEF;
        cpu_we = 0; cpu_mode = MODE_WORD; cpu_addr = 32'h10; cpu_req = 1;
        #1;
        tests++;
        if (cpu_stall !== 1'b1) begin
            fails++; $display("FAIL cpu_read_stall_k0: got %b want 1", cpu_stall);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            tests++;
            if (mem_req !== (k >= 1 && k <= 3) || cpu_done !== (k == 4) ||
                cpu_stall !== (k < 4) || dbg_done !== 1'b0) begin
                fails++;
                $display("FAIL cpu_read_timing k=%0d: got req=%b done=%b stall=%b want req=%b done=%b stall=%b",
                         k, mem_req, cpu_done, cpu_stall, (k <= 3), (k == 4), (k < 4));
            end
            if (k == 4) begin
                tests++;
                if (cpu_rdata !== 32'hDEADBEEF) begin
                    fails++; $display("FAIL cpu_read_data: got %h want deadbeef", cpu_rdata);
                end
                cpu_req = 0;
            end
        end
        exp_cpu_rd = 32'hDEADBEEF;
    endtask

    task automatic test_simultaneous();
        logic [31:0] addr_q[$];
        logic        we_q[$];
        logic [31:0] wd_q[$];
        int  nc = 0, nd = 0, cyc = 0;
        bit  first_src = 1'b0, any_done = 1'b0, prev_req = 1'b0;
        apply_reset();
        lat = 1;
        cpu_we = 0; cpu_mode = MODE_WORD; cpu_addr = 32'h20;
        dbg_we = 1; dbg_mode = MODE_WORD; dbg_addr = 32'h40; dbg_wdata = 32'h12345678;
        cpu_req = 1; dbg_req = 1;
        while (cyc < 60 && (cpu_req || dbg_req || cyc < 8)) begin
            @(negedge clk);
            cyc++;
            if (mem_req && !prev_req) begin
                addr_q.push_back(mem_addr); we_q.push_back(mem_we); wd_q.push_back(mem_wdata);
            end
            prev_req = mem_req;
            if (cpu_done) begin
                nc++; cpu_req = 0;
                if (!any_done) begin first_src = SRC_CPU; any_done = 1; end
            end
            if (dbg_done) begin
                nd++; dbg_req = 0;
                if (!any_done) begin first_src = SRC_DBG; any_done = 1; end
            end
        end
        tests++;
        if (addr_q.size() != 2) begin
            fails++; $display("FAIL simul_txn_count: got %0d want 2", addr_q.size());
        end else begin
            tests++;
            if (we_q[0] !== 1'b0 || addr_q[0] !== 32'h20) begin
                fails++; $display("FAIL simul_first_cpu: got we=%b addr=%h want we=0 addr=00000020", we_q[0], addr_q[0]);
            end
            tests++;
            if (we_q[1] !== 1'b1 || addr_q[1] !== 32'h40 || wd_q[1] !== 32'h12345678) begin
                fails++; $display("FAIL simul_second_dbg: got we=%b addr=%h wd=%h want we=1 addr=00000040 wd=12345678",
                                  we_q[1], addr_q[1], wd_q[1]);
            end
        end
        tests++;
        if (nc != 1 || nd != 1 || first_src != SRC_CPU) begin
            fails++; $display("FAIL simul_done: got cpu=%0d dbg=%0d first=%0d want 1 1 0", nc, nd, first_src);
        end
        tests++;
        if (mem_rd(32'h40) !== 32'h12345678) begin
            fails++; $display("FAIL simul_write_mem: got %h want 12345678", mem_rd(32'h40));
        end
        exp_cpu_rd = mem_rd(32'h20);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr_q[$];
        int  gap = 0, max_gap = 0, ndone = 0, cyc = 0;
        bit  prev_req = 1'b0;
        apply_reset();
        lat = 0;
        cpu_we = 0; cpu_mode = MODE_WORD; cpu_addr = 32'h100;
        dbg_we = 0; dbg_mode = MODE_WORD; dbg_addr = 32'h200;
        cpu_req = 1; dbg_req = 1;
        while (ndone < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (mem_req) begin
                if (!prev_req) begin
                    if (addr_q.size() > 0 && gap > max_gap) max_gap = gap;
                    addr_q.push_back(mem_addr);
                end
                gap = 0;
            end else begin
                gap++;
            end
            prev_req = mem_req;
            if (cpu_done || dbg_done) ndone++;
        end
        cpu_req = 0; dbg_req = 0;
        tests++;
        if (ndone != 4 || addr_q.size() != 4) begin
            fails++; $display("FAIL b2b_count: got done=%0d txns=%0d want 4 4", ndone, addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (addr_q[i] !== ((i % 2 == 0) ? 32'h100 : 32'h200)) begin
                    fails++; $display("FAIL b2b_order[%0d]: got %h want %h", i, addr_q[i],
                                      (i % 2 == 0) ? 32'h100 : 32'h200);
                end
            end
        end
        tests++;
        if (max_gap > 2) begin
            fails++; $display("FAIL b2b_gap: got %0d want <=2", max_gap);
        end
        @(negedge clk);
        exp_cpu_rd = mem_rd(32'h100);
    endtask

    task automatic test_timeout();
        int hi = 0;
        bit got = 1'b0, ok;
        lat = 2; no_ready = 1;
        dbg_we = 0; dbg_addr = 32'h80; dbg_req = 1;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (mem_req) hi++;
            if (dbg_done) begin
                got = 1;
                tests++;
                if (dbg_rdata !== 32'h0 || err_timeout !== 1'b1 || err_src !== SRC_DBG) begin
                    fails++; $display("FAIL timeout_dbg: got rdata=%h err=%b src=%b want 0 1 1",
                                      dbg_rdata, err_timeout, err_src);
                end
            end
        end
        dbg_req = 0;
        tests++;
        if (!got || hi != 15) begin
            fails++; $display("FAIL timeout_len: got done=%b req_cycles=%0d want 1 15", got, hi);
        end
        // A second timeout must not overwrite the first source
        cpu_we = 0; cpu_addr = 32'h84; cpu_req = 1;
        wait_done(SRC_CPU, ok);
        cpu_req = 0;
        tests++;
        if (!ok || cpu_rdata !== 32'h0 || err_timeout !== 1'b1 || err_src !== SRC_DBG) begin
            fails++; $display("FAIL timeout_second: got done=%b rdata=%h err=%b src=%b want 1 0 1 1",
                              ok, cpu_rdata, err_timeout, err_src);
        end
        no_ready = 0;
        @(negedge clk);
        cpu_addr = 32'h88; cpu_req = 1;
        wait_done(SRC_CPU, ok);
        cpu_req = 0;
        tests++;
        if (!ok || cpu_rdata !== mem_rd(32'h88) || err_timeout !== 1'b1) begin
            fails++; $display("FAIL timeout_sticky: got done=%b rdata=%h err=%b want 1 %h 1",
                              ok, cpu_rdata, err_timeout, mem_rd(32'h88));
        end
        exp_cpu_rd = mem_rd(32'h88);
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        tests++;
        if (err_timeout !== 1'b0 || err_src !== 1'b0) begin
            fails++; $display("FAIL err_clr: got err=%b src=%b want 0 0", err_timeout, err_src);
        end
    endtask

    task automatic test_mode();
        bit ok, seen = 1'b0;
        logic [31:0] wd;
        lat = 1;
        wd = $urandom;
        cpu_we = 1; cpu_mode = MODE_SBYTE; cpu_addr = 32'h3; cpu_wdata = wd; cpu_req = 1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = mem_req;
        end
        tests++;
        if (!seen || mem_mode !== MODE_SBYTE || mem_addr !== 32'h3 || mem_we !== 1'b1 || mem_wdata !== wd) begin
            fails++; $display("FAIL mode_fields: got req=%b mode=%b addr=%h we=%b wd=%h want 1 01 00000003 1 %h",
                              seen, mem_mode, mem_addr, mem_we, mem_wdata, wd);
        end
        // Fields changed mid-transaction must not reach the memory
        cpu_addr = 32'h7; cpu_wdata = ~wd; cpu_mode = MODE_UBYTE;
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h3 || mem_wdata !== wd || mem_mode !== MODE_SBYTE) begin
            fails++; $display("FAIL mode_latched: got req=%b addr=%h mode=%b want 1 00000003 01",
                              mem_req, mem_addr, mem_mode);
        end
        wait_done(SRC_CPU, ok);
        cpu_req = 0;
        tests++;
        if (!ok || cpu_rdata !== exp_cpu_rd) begin
            fails++; $display("FAIL mode_rdata_kept: got done=%b rdata=%h want 1 %h", ok, cpu_rdata, exp_cpu_rd);
        end
        @(negedge clk);
    endtask

    task automatic test_stray_ready();
        bit bad = 1'b0;
        stray_ready = 1;
        repeat (4) begin
            @(negedge clk);
            if (cpu_done || dbg_done || mem_req) bad = 1;
        end
        stray_ready = 0;
        @(negedge clk);
        tests++;
        if (bad || cpu_rdata !== exp_cpu_rd) begin
            fails++; $display("FAIL stray_ready: got spurious=%b rdata=%h want 0 %h", bad, cpu_rdata, exp_cpu_rd);
        end
    endtask

    task automatic test_reset_mid();
        bit bad = 1'b0, ok;
        lat = 0; no_ready = 1;
        cpu_we = 0; cpu_mode = MODE_WORD; cpu_addr = 32'h30; cpu_req = 1;
        repeat (3) @(negedge clk);
        tests++;
        if (mem_req !== 1'b1) begin
            fails++; $display("FAIL rst_mid_pre: got mem_req=%b want 1", mem_req);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (mem_req !== 1'b0) begin
            fails++; $display("FAIL rst_mid_async: got mem_req=%b want 0", mem_req);
        end
        cpu_req = 0; no_ready = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_done || dbg_done) bad = 1;
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (cpu_done || dbg_done) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++; $display("FAIL rst_mid_nodone: got done pulse want none");
        end
        cpu_addr = 32'h34; dbg_we = 0; dbg_addr = 32'h38;
        cpu_req = 1; dbg_req = 1;
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h34) begin
            fails++; $display("FAIL rst_mid_tie: got req=%b addr=%h want 1 00000034", mem_req, mem_addr);
        end
        wait_done(SRC_CPU, ok);
        cpu_req = 0;
        tests++;
        if (!ok || cpu_rdata !== mem_rd(32'h34)) begin
            fails++; $display("FAIL rst_mid_read: got done=%b rdata=%h want 1 %h", ok, cpu_rdata, mem_rd(32'h34));
        end
        wait_done(SRC_DBG, ok);
        dbg_req = 0;
        @(negedge clk);
    endtask

    // Random traffic from both ports; the model checks each grant against the
    // round-robin rule and each completion against the memory contents.
    task automatic test_random();
        bit cpu_fin = 1'b0, dbg_fin = 1'b0;
        apply_reset();
        fork
            begin
                bit ok;
                for (int i = 0; i < 14; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    cpu_we = 1'($urandom_range(0, 1)); cpu_mode = 2'($urandom_range(0, 2));
                    cpu_addr = 32'($urandom_range(0, 15)) << 2; cpu_wdata = $urandom; cpu_req = 1;
                    wait_done(SRC_CPU, ok);
                    tests++;
                    if (!ok) begin fails++; $display("FAIL rnd_cpu_hang: got no done want done"); end
                    if ($urandom_range(0, 1) == 1) cpu_req = 0;
                end
                cpu_req = 0;
                cpu_fin = 1;
            end
            begin
                bit ok;
                for (int i = 0; i < 14; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    dbg_we = 1'($urandom_range(0, 1)); dbg_mode = 2'($urandom_range(0, 2));
                    dbg_addr = 32'($urandom_range(0, 15)) << 2; dbg_wdata = $urandom; dbg_req = 1;
                    wait_done(SRC_DBG, ok);
                    tests++;
                    if (!ok) begin fails++; $display("FAIL rnd_dbg_hang: got no done want done"); end
                    if ($urandom_range(0, 1) == 1) dbg_req = 0;
                end
                dbg_req = 0;
                dbg_fin = 1;
            end
            begin
                bit          last = SRC_DBG, busy = 1'b0, own = SRC_CPU, src;
                logic [31:0] ref_rd [2];
                logic [31:0] exp_rd = 32'h0, got_rd;
                logic        e_we;
                logic [1:0]  e_mode;
                logic [31:0] e_addr, e_wd;
                ref_rd[0] = 32'h0; ref_rd[1] = 32'h0;
                for (int c = 0; c < 5000 && !(cpu_fin && dbg_fin); c++) begin
                    @(posedge clk);
                    #1;
                    if (mem_req && !busy) begin
                        src  = (cpu_req && dbg_req) ? ~last : (dbg_req ? SRC_DBG : SRC_CPU);
                        last = src;
                        e_we   = src ? dbg_we : cpu_we;     e_mode = src ? dbg_mode : cpu_mode;
                        e_addr = src ? dbg_addr : cpu_addr; e_wd   = src ? dbg_wdata : cpu_wdata;
                        tests++;
                        if ({mem_we, mem_mode, mem_addr, mem_wdata} !== {e_we, e_mode, e_addr, e_wd}) begin
                            fails++; $display("FAIL rnd_grant: got we=%b mode=%b addr=%h wd=%h want src=%0d we=%b mode=%b addr=%h wd=%h",
                                              mem_we, mem_mode, mem_addr, mem_wdata, src, e_we, e_mode, e_addr, e_wd);
                        end
                        exp_rd = e_we ? ref_rd[src] : mem_rd(e_addr);
                        lat  = $urandom_range(0, 4);
                        busy = 1; own = src;
                    end
                    if (cpu_done || dbg_done) begin
                        got_rd = own ? dbg_rdata : cpu_rdata;
                        tests++;
                        if (!busy || {dbg_done, cpu_done} !== (own ? 2'b10 : 2'b01) || got_rd !== exp_rd) begin
                            fails++; $display("FAIL rnd_done: got dbg_done=%b cpu_done=%b rdata=%h want owner=%0d rdata=%h",
                                              dbg_done, cpu_done, got_rd, own, exp_rd);
                        end
                        ref_rd[own] = exp_rd;
                        busy = 0;
                    end
                end
            end
        join
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_simultaneous();
        test_back_to_back();
        test_timeout();
        test_mode();
        test_stray_ready();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
